// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_DATA    = 3'd3,
    ST_CSUM    = 3'd4,
    ST_RELEASE = 3'd5,
    ST_RUN     = 3'd6,
    ST_ERR     = 3'd7
  } loader_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port and core control out.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            s_byte;
  logic                  s_valid;
  logic                  s_ready;
  logic [31:0]           imem_din;
  logic                  imem_web;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  core_rstn;
  logic                  done;
  logic                  error;

  modport master (
    input  s_byte, s_valid,
    output s_ready, imem_din, imem_web, imem_addr, core_rstn, done, error
  );

  modport slave (
    output s_byte, s_valid,
    input  s_ready, imem_din, imem_web, imem_addr, core_rstn, done, error
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid_o marks the
// cycle the 4th byte is presented, with word_o already including that byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift_q <= 24'h000000;
      cnt_q   <= 2'd0;
    end else if (valid_i) begin
      shift_q <= {byte_i, shift_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = valid_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header + data byte stream -> instruction-memory word writes, then core release.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MAX_WORDS      = 1024,
  parameter int                    RELEASE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rstn,
  imem_loader_if.master   bus
);

  loader_state_t         state_q;
  logic                  s_ready_q;
  logic [31:0]           din_q;
  logic                  web_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  core_rstn_q;
  logic                  done_q;
  logic                  error_q;
  logic [7:0]            n_lo_q;
  logic [15:0]           n_q;
  logic [15:0]           k_q;
  logic [15:0]           rel_q;

  logic                  accept_s;
  logic                  pack_valid_s;
  logic [31:0]           word_s;
  logic                  word_valid_s;
  logic [15:0]           hdr_n_s;

  assign accept_s     = bus.s_valid && s_ready_q;
  assign pack_valid_s = accept_s && (state_q == ST_DATA);
  assign hdr_n_s      = {bus.s_byte, n_lo_q};

  byte_packer u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .byte_i       (bus.s_byte),
    .valid_i      (pack_valid_s),
    .word_o       (word_s),
    .word_valid_o (word_valid_s)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      csum_q <= 8'h00;
    end else if (pack_valid_s) begin
      csum_q <= csum_q ^ bus.s_byte;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      din_q       <= 32'h0000_0000;
      web_q       <= 1'b1;
      addr_q      <= BASE_ADDR;
      waddr_q     <= BASE_ADDR;
      core_rstn_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      n_lo_q      <= 8'h00;
      n_q         <= 16'h0000;
      k_q         <= 16'h0000;
      rel_q       <= 16'h0000;
    end else begin
      web_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          state_q   <= ST_HDR0;
          s_ready_q <= 1'b1;
        end
        ST_HDR0: begin
          if (accept_s) begin
            n_lo_q  <= bus.s_byte;
            state_q <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (accept_s) begin
            n_q <= hdr_n_s;
            k_q <= 16'h0000;
            if (hdr_n_s == 16'h0000) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q   <= ST_CSUM;
`else
              state_q   <= ST_RELEASE;
              s_ready_q <= 1'b0;
              rel_q     <= 16'h0000;
`endif
            end else if (hdr_n_s > 16'(MAX_WORDS)) begin
              state_q   <= ST_ERR;
              s_ready_q <= 1'b0;
              error_q   <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Write is issued on the same edge that takes the word's last byte.
          if (word_valid_s) begin
            din_q   <= word_s;
            web_q   <= 1'b0;
            addr_q  <= waddr_q;
            waddr_q <= waddr_q + ADDR_WIDTH'(4);
            k_q     <= k_q + 16'd1;
            if (k_q == n_q - 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q   <= ST_CSUM;
`else
              state_q   <= ST_RELEASE;
              s_ready_q <= 1'b0;
              rel_q     <= 16'h0000;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM: begin
          if (accept_s) begin
            s_ready_q <= 1'b0;
            rel_q     <= 16'h0000;
            if (bus.s_byte == csum_q) begin
              state_q <= ST_RELEASE;
            end else begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        ST_RELEASE: begin
          if (rel_q == 16'(RELEASE_CYCLES - 1)) begin
            core_rstn_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= ST_RUN;
          end else begin
            rel_q <= rel_q + 16'd1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          state_q     <= ST_ERR;
          s_ready_q   <= 1'b0;
          core_rstn_q <= 1'b0;
          error_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.imem_din  = din_q;
  assign bus.imem_web  = web_q;
  assign bus.imem_addr = addr_q;
  assign bus.core_rstn = core_rstn_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and popped when the write strobe is seen.
`timescale 1ns/1ps
module tb_imem_loader;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;
  int   wr_cnt;
  time  acc_t;
  time  wr_t;
  time  rise_t;
  logic core_rstn_prev;
  logic [63:0] exp_q[$];
  logic [31:0] wbuf[4];

  imem_loader_if #(.ADDR_WIDTH(32)) bus();

  imem_loader dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor and core_rstn edge capture, sampled mid-cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rstn && bus.imem_web == 1'b0) begin
      wr_cnt++;
      wr_t = $time - 5;
      if (exp_q.size() == 0) begin
        check("extra_wr", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.imem_addr), 64'(e[63:32]));
        check("wr_data", 64'(bus.imem_din), 64'(e[31:0]));
      end
    end
    if (bus.core_rstn && !core_rstn_prev) rise_t = $time - 5;
    core_rstn_prev = bus.core_rstn;
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    wr_cnt = 0;
    rstn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    int gap;
    int tmo;
    gap = (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_byte  = b;
    tmo = 0;
    while (!bus.s_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) check("ready_tmo", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    acc_t = $time - 5;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_prog(input int n, input int gmax, input int stop_after, input logic [7:0] flip);
    logic [15:0] nn;
    logic [31:0] w;
    logic [7:0]  x;
    int          sent;
    nn = 16'(n);
    x = 8'h00;
    sent = 0;
    send_byte(nn[7:0], gmax);
    send_byte(nn[15:8], gmax);
    for (int k = 0; k < n; k++) begin
      w = wbuf[k];
      for (int b = 0; b < 4; b++) begin
        if (sent == stop_after) return;
        if (b == 3) exp_q.push_back({32'(4 * k), w});
        x = x ^ w[8*b +: 8];
        send_byte(w[8*b +: 8], gmax);
        sent++;
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(x ^ flip, gmax);
`else
    if (flip != 8'h00) x = 8'h00;
`endif
  endtask

  task automatic wait_release(input int n);
    int  t;
    time ref_t;
    t = 0;
    while (!bus.core_rstn && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rel_tmo", 64'(bus.core_rstn), 64'd1);
    @(negedge clk);
`ifdef IMEM_LOADER_CSUM_EN
    ref_t = acc_t;
`else
    ref_t = (n == 0) ? acc_t : wr_t;
`endif
    check("rel_lat", 64'((rise_t - ref_t) / 10), 64'd4);
    check("done", 64'(bus.done), 64'd1);
    check("rdy_run", 64'(bus.s_ready), 64'd0);
    check("no_pend", 64'(exp_q.size()), 64'd0);
    check("wr_cnt", 64'(wr_cnt), 64'(n));
    check("no_err", 64'(bus.error), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_cnt = 0;
    acc_t = 0;
    wr_t = 0;
    rise_t = 0;
    core_rstn_prev = 1'b0;
    rstn = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_byte = 8'h00;
    wbuf[0] = 32'h0050_0113;
    wbuf[1] = 32'h00C0_0193;
    wbuf[2] = 32'hDEAD_BEEF;
    wbuf[3] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.s_ready), 64'd0);
    check("rst_web", 64'(bus.imem_web), 64'd1);
    check("rst_din", 64'(bus.imem_din), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_crstn", 64'(bus.core_rstn), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.error), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_up", 64'(bus.s_ready), 64'd1);

    // Two words, continuous stream.
    send_prog(2, 0, -1, 8'h00);
    wait_release(2);

    // Same program with random valid gaps.
    do_reset();
    send_prog(2, 3, -1, 8'h00);
    wait_release(2);

    // Four words with gaps, including a word with all high bits set.
    do_reset();
    send_prog(4, 2, -1, 8'h00);
    wait_release(4);

    // Empty program.
    do_reset();
    send_prog(0, 0, -1, 8'h00);
    wait_release(0);

    // Oversized header aborts.
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("ovf_ready", 64'(bus.s_ready), 64'd0);
    repeat (10) @(negedge clk);
    check("ovf_err", 64'(bus.error), 64'd1);
    check("ovf_crstn", 64'(bus.core_rstn), 64'd0);
    check("ovf_wr", 64'(wr_cnt), 64'd0);

    // Reset mid-word discards the partial word, then reload from base.
    do_reset();
    send_prog(2, 0, 6, 8'h00);
    repeat (2) @(negedge clk);
    check("mid_wr", 64'(wr_cnt), 64'd1);
    do_reset();
    @(negedge clk);
    check("mid_addr", 64'(bus.imem_addr), 64'd0);
    check("mid_crstn", 64'(bus.core_rstn), 64'd0);
    check("mid_err", 64'(bus.error), 64'd0);
    send_prog(2, 1, -1, 8'h00);
    wait_release(2);

`ifdef IMEM_LOADER_CSUM_EN
    // Good checksum (0x42) releases, bad checksum (0x43) aborts.
    do_reset();
    send_prog(1, 0, -1, 8'h00);
    wait_release(1);
    do_reset();
    send_prog(1, 0, -1, 8'h01);
    repeat (10) @(negedge clk);
    check("cs_err", 64'(bus.error), 64'd1);
    check("cs_crstn", 64'(bus.core_rstn), 64'd0);
    check("cs_done", 64'(bus.done), 64'd0);
    check("cs_wr", 64'(wr_cnt), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
